ms_timer: RTL and testbench
===========================

// Module: ms_timer
// PURPOSE
//   Millisecond up/down timer for the reaction-time game. It feeds timer_value to the
//   reaction-time FSM and takes the FSM's reset/up/enable outputs as controls.
//   A clock prescaler produces 1 ms ticks. The count saturates at 0 when counting down
//   and at MAX_MS when counting up. A load port presets the random delay before the
//   LED turns on.
// PARAMETERS
//   MAX_MS       2047    saturation ceiling in ms; must equal 2**k-1 (elaboration assertion)
//   CLKS_PER_MS  50000   clk cycles per ms tick (50 MHz board clock); must be >= 2
// PORTS
//   clk          in   1                 system clock; all logic on posedge
//   reset        in   1                 synchronous, active-high; clears count and prescaler
//   enable       in   1                 1 = prescaler runs and count may change; 0 = hold
//   up           in   1                 1 = count up toward MAX_MS; 0 = count down toward 0
//   load         in   1                 1-cycle strobe: preset count from load_value
//   load_value   in   $clog2(MAX_MS)    preset value in ms
//   timer_value  out  $clog2(MAX_MS)    current count in ms (registered)
//   ms_tick      out  1                 1-cycle pulse on each edge that applies a tick
//   at_zero      out  1                 timer_value == 0 (combinational from register)
//   at_max       out  1                 timer_value == MAX_MS (combinational from register)
// BEHAVIOUR
//   - One clock, one synchronous active-high reset.
//   - Reset values: timer_value=0, prescaler=0, ms_tick=0, at_zero=1, at_max=0.
//   - Per-edge priority: reset > load > tick > hold.
//     - reset: count=0, prescaler=0, ms_tick=0.
//     - load (no reset): count=load_value, prescaler=0, ms_tick=0.
//       load_value is stored as-is; it cannot exceed MAX_MS by construction.
//       The enable and up inputs are ignored on the load cycle.
//     - enable=1: prescaler increments each edge.
//       When prescaler==CLKS_PER_MS-1, it wraps to 0 on that edge and a tick is applied.
//     - tick, up=1: count+1, but held when count==MAX_MS.
//     - tick, up=0: count-1, but held when count==0.
//     - ms_tick=1 for exactly the cycle in which the updated count is visible.
//       ms_tick also pulses on saturated ticks.
//     - enable=0: prescaler and count hold; ms_tick=0.
//   - Timing:
//     - The first tick after reset/load with enable held high lands CLKS_PER_MS edges later.
//     - The count changes on that same edge, so latency from tick condition to timer_value
//       is 1 clk.
//   - Changing up mid-millisecond does not clear the prescaler.
//     The next tick uses the up value sampled on the tick edge.
//   - Deasserting enable mid-millisecond freezes the prescaler phase.
//     Re-enabling resumes the partial millisecond and does not restart it.
//   - Arithmetic: the counter is an unsigned width-$clog2(MAX_MS) register.
//     Saturation compares occur before the add/subtract, so no wrap is ever possible.
//   - Reset or load mid-millisecond discards the partial prescaler count.
//   - No combinational path from any input to any output.
// TESTING  (CLKS_PER_MS=4, MAX_MS=15 unless noted)
//   1. reset 1 cycle, then enable=1, up=1 for 40 clks
//      -> timer_value=10; ms_tick pulses every 4th clk; first pulse on clk 4.
//   2. load=1, load_value=3, then enable=1, up=0 for 20 clks
//      -> 3,2,1,0 at clks 4,8,12; holds 0 afterwards; at_zero=1; ms_tick keeps pulsing.
//   3. count up from 13 for 16 clks -> 14,15 then holds 15; at_max=1; never wraps to 0.
//   4. enable=1 for 2 clks, enable=0 for 10 clks, enable=1 again
//      -> count unchanged while disabled; next tick exactly 2 clks after re-enable.
//   5. same edge: reset=1, load=1, tick pending -> timer_value=0, ms_tick=0.
//      Same edge: load=1 and tick pending -> timer_value=load_value, ms_tick=0.
//   6. reset asserted mid-millisecond (prescaler=2), then released with enable=1
//      -> first tick 4 clks after release; up toggled at prescaler=1 takes effect on that tick.

Source files
------------

// File: rtl/ms_timer.sv
// Millisecond up/down timer for the reaction-time game: prescaled 1 ms ticks,
// saturating count in [0, MAX_MS], synchronous preset via load.
module ms_timer #(
  parameter int unsigned MAX_MS      = 2047,
  parameter int unsigned CLKS_PER_MS = 50000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      up,
  input  logic                      load,
  input  logic [$clog2(MAX_MS)-1:0] load_value,
  output logic [$clog2(MAX_MS)-1:0] timer_value,
  output logic                      ms_tick,
  output logic                      at_zero,
  output logic                      at_max
);

  localparam int unsigned W  = $clog2(MAX_MS);
  localparam int unsigned PW = $clog2(CLKS_PER_MS);

  localparam logic [W-1:0]  CNT_MAX = W'(MAX_MS);
  localparam logic [PW-1:0] PS_LAST = PW'(CLKS_PER_MS - 1);

  if ((((MAX_MS + 1) & MAX_MS) != 0) || (MAX_MS < 3)) begin : g_bad_max_ms
    $error("ms_timer: MAX_MS must be 2**k-1 with k >= 2");
  end
  if (CLKS_PER_MS < 2) begin : g_bad_clks_per_ms
    $error("ms_timer: CLKS_PER_MS must be >= 2");
  end

  logic [PW-1:0] prescaler;
  logic [W-1:0]  count;
  logic          tick;
  logic [W-1:0]  count_next;

  assign tick = enable && (prescaler == PS_LAST);

  // Saturation is decided before the add/subtract, so the counter never wraps.
  always_comb begin
    count_next = count;
    if (up) begin
      if (count != CNT_MAX) count_next = count + W'(1);
    end else begin
      if (count != '0) count_next = count - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      prescaler <= '0;
      ms_tick   <= 1'b0;
    end else if (load) begin
      count     <= load_value;
      prescaler <= '0;
      ms_tick   <= 1'b0;
    end else if (enable) begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      ms_tick   <= tick;
      if (tick) count <= count_next;
    end else begin
      ms_tick <= 1'b0;
    end
  end

  assign timer_value = count;
  assign at_zero     = (count == '0);
  assign at_max      = (count == CNT_MAX);

endmodule

// File: tb/tb_ms_timer.sv
// Bench for ms_timer (MAX_MS=15, CLKS_PER_MS=4): directed table, corner sequences
// and randomized traffic checked against an arithmetic reference model.
module tb_ms_timer;

  localparam int MAXV = 15;
  localparam int CPM  = 4;
  localparam int W    = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] timer_value;
  logic         ms_tick;
  logic         at_zero;
  logic         at_max;

  ms_timer #(.MAX_MS(MAXV), .CLKS_PER_MS(CPM)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .up          (up),
    .load        (load),
    .load_value  (load_value),
    .timer_value (timer_value),
    .ms_tick     (ms_tick),
    .at_zero     (at_zero),
    .at_max      (at_max)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: enabled edges since last reset/load, and the count in ms.
  int m_phase = 0;
  int m_cnt   = 0;
  bit m_tick  = 0;

  typedef struct {
    bit r;
    bit l;
    int lv;
    bit e;
    bit u;
    int val;
    bit tk;
  } vec_t;

  vec_t vecs[30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit l, input int lv, input bit e, input bit u);
    m_tick = 0;
    if (r) begin
      m_cnt = 0; m_phase = 0;
    end else if (l) begin
      m_cnt = lv; m_phase = 0;
    end else if (e) begin
      m_phase++;
      if (m_phase == CPM) begin
        m_phase = 0;
        m_tick  = 1;
        m_cnt   = u ? ((m_cnt + 1 > MAXV) ? MAXV : m_cnt + 1)
                    : ((m_cnt - 1 < 0) ? 0 : m_cnt - 1);
      end
    end
  endtask

  task automatic step(input bit r, input bit l, input int lv, input bit e, input bit u);
    reset = r; load = l; load_value = W'(lv); enable = e; up = u;
    @(posedge clk);
    model_edge(r, l, lv, e, u);
    #1;
    chk("timer_value", 32'(timer_value), 32'(m_cnt));
    chk("ms_tick",     32'(ms_tick),     32'(m_tick));
    chk("at_zero",     32'(at_zero),     32'(m_cnt == 0));
    chk("at_max",      32'(at_max),      32'(m_cnt == MAXV));
  endtask

  initial begin
    // r, l, lv, e, u, expected value, expected tick
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 1, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 1, 1, 1};
    vecs[5]  = '{0, 0, 0, 1, 0, 1, 0};
    vecs[6]  = '{0, 0, 0, 1, 0, 1, 0};
    vecs[7]  = '{0, 0, 0, 1, 0, 1, 0};
    vecs[8]  = '{0, 0, 0, 1, 0, 0, 1};
    vecs[9]  = '{0, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 1, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 1, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 1, 0, 0, 1};
    vecs[13] = '{0, 0, 0, 1, 1, 0, 0};
    vecs[14] = '{0, 0, 0, 1, 1, 0, 0};
    vecs[15] = '{0, 0, 0, 1, 1, 0, 0};
    vecs[16] = '{1, 1, 9, 1, 1, 0, 0};
    vecs[17] = '{0, 0, 0, 1, 1, 0, 0};
    vecs[18] = '{0, 0, 0, 1, 1, 0, 0};
    vecs[19] = '{0, 0, 0, 1, 1, 0, 0};
    vecs[20] = '{0, 1, 9, 1, 1, 9, 0};
    vecs[21] = '{0, 0, 0, 1, 1, 9, 0};
    vecs[22] = '{0, 0, 0, 1, 1, 9, 0};
    vecs[23] = '{0, 0, 0, 1, 1, 9, 0};
    vecs[24] = '{0, 0, 0, 1, 1, 10, 1};
    vecs[25] = '{0, 1, 15, 1, 0, 15, 0};
    vecs[26] = '{0, 0, 0, 1, 1, 15, 0};
    vecs[27] = '{0, 0, 0, 1, 1, 15, 0};
    vecs[28] = '{0, 0, 0, 1, 1, 15, 0};
    vecs[29] = '{0, 0, 0, 1, 1, 15, 1};

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].l, vecs[i].lv, vecs[i].e, vecs[i].u);
      chk($sformatf("vec%0d_value", i), 32'(timer_value), 32'(vecs[i].val));
      chk($sformatf("vec%0d_tick", i),  32'(ms_tick),     32'(vecs[i].tk));
    end

    // Count up 40 clks from reset: pulse on every 4th edge, ends at 10.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 1, 1);
      chk("up40_tick", 32'(ms_tick), 32'((i % 4) == 3));
    end
    chk("up40_final", 32'(timer_value), 32'd10);

    // Count down from 3: reaches 0 and holds while ticks keep pulsing.
    step(0, 1, 3, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
    chk("down_final", 32'(timer_value), 32'd0);
    chk("down_at_zero", 32'(at_zero), 32'd1);
    chk("down_sat_tick", 32'(ms_tick), 32'd1);

    // Count up from 13: saturates at 15, never wraps.
    step(0, 1, 13, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 1);
      chk("up_sat_nonzero", 32'(timer_value != 0), 32'd1);
    end
    chk("up_sat_final", 32'(timer_value), 32'd15);
    chk("up_sat_at_max", 32'(at_max), 32'd1);

    // Enable freeze: 2 enabled edges, 10 disabled, tick 2 edges after re-enable.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 1);
      chk("frozen_value", 32'(timer_value), 32'd0);
    end
    step(0, 0, 0, 1, 1);
    chk("resume_no_tick", 32'(ms_tick), 32'd0);
    step(0, 0, 0, 1, 1);
    chk("resume_tick", 32'(ms_tick), 32'd1);
    chk("resume_value", 32'(timer_value), 32'd1);

    // Reset at prescaler=2 discards the partial ms; up toggled mid-ms applies on the tick.
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("rst_mid_t1", 32'(ms_tick), 32'd0);
    step(0, 0, 0, 1, 1);
    chk("rst_mid_t2", 32'(ms_tick), 32'd0);
    step(0, 0, 0, 1, 1);
    chk("rst_mid_t3", 32'(ms_tick), 32'd0);
    step(0, 0, 0, 1, 1);
    chk("rst_mid_t4", 32'(ms_tick), 32'd1);
    chk("rst_mid_value", 32'(timer_value), 32'd1);

    // Randomized traffic, direction bias flips every 300 edges to reach both rails.
    for (int i = 0; i < 3000; i++) begin
      bit r, l, e, u;
      int lv;
      r  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 39) == 0);
      lv = int'($urandom_range(0, MAXV));
      e  = ($urandom_range(0, 7) != 0);
      if (((i / 300) % 2) == 0) u = ($urandom_range(0, 7) != 0);
      else                      u = ($urandom_range(0, 7) == 0);
      step(r, l, lv, e, u);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
